// File: rtl/tiny_alu_pkg.sv
// ----------------------------------------------------------------------------
// tiny_alu_pkg
// Shared types and constants for the TinyALU responder.
//   operation_t : opcode encoding carried on the command interface
//   state_t     : control FSM states
//   SC_LAT      : latency of add/and/xor (and of mul when no multiplier)
//   MUL_LAT     : latency of mul through the 3-stage multiplier
// Configuration macro: TINYALU_MUL_EN selects whether mul uses MUL_LAT.
// ----------------------------------------------------------------------------
package tiny_alu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int SC_LAT  = 1;
    localparam int MUL_LAT = 3;

    // Opcodes 1..4 start an operation; everything else is ignored in IDLE.
    function automatic logic is_exec(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // BUSY countdown preload: latency minus the completion cycle itself.
    function automatic logic [1:0] lat_cnt(input logic [2:0] op);
`ifdef TINYALU_MUL_EN
        if (op == mul_op) return 2'(MUL_LAT - 1);
`endif
        return 2'(SC_LAT - 1);
    endfunction

endpackage

// File: rtl/tinyalu_core_if.sv
// ----------------------------------------------------------------------------
// tinyalu_if
// Start/done command interface between an initiator and the TinyALU.
//   A, B   : 8-bit unsigned operands
//   op     : 3-bit opcode (see tiny_alu_pkg::operation_t)
//   start  : request, held by the initiator until after done
//   done   : one-cycle completion pulse
//   result : 16-bit result, held until the next completion
// Modports: master = initiator (bench BFM), slave = ALU.
// ----------------------------------------------------------------------------
interface tinyalu_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    modport master (output A, B, op, start, input  done, result);
    modport slave  (input  A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_mult_pipe.sv
// ----------------------------------------------------------------------------
// tinyalu_mult_pipe
// 3-stage registered 8x8 unsigned multiplier with a valid shift chain.
//   clk, reset_n : clock, async active-low reset (flushes the pipe)
//   i_vld        : load i_a/i_b into stage 1
//   i_a, i_b     : operands
//   o_vld        : o_prod valid (two edges after i_vld was sampled)
//   o_prod       : full 16-bit product
// Each stage only loads when its valid input is set, so data holds between
// operations.
// ----------------------------------------------------------------------------
module tinyalu_mult_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_vld,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_vld,
    output logic [15:0] o_prod
);

    logic [2:0]  r_vld_pipe;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_p1;
    logic [15:0] r_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1:0], i_vld};
            if (i_vld) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            if (r_vld_pipe[0]) r_p1 <= 16'(r_a) * 16'(r_b);
            if (r_vld_pipe[1]) r_p2 <= r_p1;
        end
    end

    assign o_vld  = r_vld_pipe[2];
    assign o_prod = r_p2;

endmodule

// File: rtl/tinyalu_core.sv
// ----------------------------------------------------------------------------
// tinyalu_core
// TinyALU responder: captures A/B/op on start, computes, answers with a
// one-cycle done pulse and a held 16-bit result.
//   clk     : rising-edge clock
//   reset_n : async active-low reset (clears done/result, flushes multiplier)
//   bus     : tinyalu_if.slave command interface
// Configuration macro: TINYALU_MUL_EN
//   defined   -> 3-stage multiplier, mul latency 3
//   undefined -> no multiplier, mul completes with latency 1 and result 0
// ----------------------------------------------------------------------------
module tinyalu_core
    import tiny_alu_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    tinyalu_if.slave  bus
);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    operation_t  r_op;
    logic [1:0]  r_cnt;
    logic        r_done;
    logic [15:0] r_result;

    logic        w_cap;
    logic        w_fin;
    logic        w_mul_ok;
    logic [15:0] w_res;

`ifdef TINYALU_MUL_EN
    logic        w_mul_vld;
    logic [15:0] w_mul_prod;

    // Fed straight from the bus on the capture edge so that stage 3 is valid
    // one cycle before the latency-3 completion edge.
    tinyalu_mult_pipe u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .i_vld   (w_cap && (bus.op == mul_op)),
        .i_a     (bus.A),
        .i_b     (bus.B),
        .o_vld   (w_mul_vld),
        .o_prod  (w_mul_prod)
    );

    assign w_mul_ok = (r_op != mul_op) || w_mul_vld;
`else
    assign w_mul_ok = 1'b1;
`endif

    assign w_cap = (r_state == IDLE) && bus.start && is_exec(bus.op);
    assign w_fin = (r_state == BUSY) && (r_cnt == 2'd0) && w_mul_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_cap)      w_state_nxt = BUSY;
            BUSY:    if (w_fin)      w_state_nxt = HOLD;
            HOLD:    if (!bus.start) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_res = 16'h0000;
        unique case (r_op)
            add_op:  w_res = {7'd0, 9'(r_a) + 9'(r_b)};
            and_op:  w_res = {8'd0, r_a & r_b};
            xor_op:  w_res = {8'd0, r_a ^ r_b};
`ifdef TINYALU_MUL_EN
            mul_op:  w_res = w_mul_prod;
`else
            mul_op:  w_res = 16'h0000;
`endif
            default: w_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= no_op;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_cap) begin
                r_a   <= bus.A;
                r_b   <= bus.B;
                r_op  <= operation_t'(bus.op);
                r_cnt <= lat_cnt(bus.op);
            end else if ((r_state == BUSY) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            r_done <= w_fin;
            if (w_fin) r_result <= w_res;
        end
    end

    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
